// File: rtl/static_pointer_pkg.sv
// static_pointer_pkg: shared constants and command type for the static pointer.
//   SP_WIDTH            pointer width
//   SP_*_DEFAULT        default legal window and reset value
//   sp_cmd_e            decoded command, one per cycle
//   decode_cmd()        priority decoder: load > write > inc
package static_pointer_pkg;

    localparam int unsigned SP_WIDTH = 16;

    localparam logic [SP_WIDTH-1:0] SP_BASE_DEFAULT  = 16'h2800;
    localparam logic [SP_WIDTH-1:0] SP_LIMIT_DEFAULT = 16'h2FFF;
    localparam logic [SP_WIDTH-1:0] SP_RESET_DEFAULT = 16'h2800;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_WRITE,
        CMD_INC
    } sp_cmd_e;

    // Only the highest-priority asserted command survives decoding.
    function automatic sp_cmd_e decode_cmd(input logic load, input logic write,
                                           input logic inc);
        sp_cmd_e cmd;
        if (load) begin
            cmd = CMD_LOAD;
        end else if (write) begin
            cmd = CMD_WRITE;
        end else if (inc) begin
            cmd = CMD_INC;
        end else begin
            cmd = CMD_NONE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/static_pointer_range_check.sv
// sp_range_check: unsigned inclusive window comparator.
//   value     value under test
//   base      lowest legal value
//   limit     highest legal value
//   in_range  1 when base <= value <= limit
module sp_range_check
    import static_pointer_pkg::*;
#(
    parameter int unsigned WIDTH = SP_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    output logic             in_range
);

    assign in_range = (value >= base) && (value <= limit);

endmodule

// File: rtl/static_pointer.sv
// static_pointer: 16-bit pointer register with load, range-checked write and increment.
//   clk            rising-edge clock
//   reset          asynchronous active-high reset, pointer -> SP_RESET
//   load_sp        unchecked load of sp_data_in
//   inc_sp         pointer + 1, wraps at 2^16
//   write_sp       range-checked load of sp_data_in
//   sp_data_in     load/write data
//   sp_data_out    registered pointer value
//   invalid_write  registered: the previous cycle's write_sp was rejected
// Build option: define STATIC_POINTER_RANGE_CHECK_EN to enable the write range
// check; without it write_sp acts as load_sp and invalid_write is tied low.
module static_pointer
    import static_pointer_pkg::*;
#(
    parameter logic [SP_WIDTH-1:0] SP_BASE  = SP_BASE_DEFAULT,
    parameter logic [SP_WIDTH-1:0] SP_LIMIT = SP_LIMIT_DEFAULT,
    parameter logic [SP_WIDTH-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_sp,
    input  logic                inc_sp,
    input  logic                write_sp,
    input  logic [SP_WIDTH-1:0] sp_data_in,
    output logic [SP_WIDTH-1:0] sp_data_out,
    output logic                invalid_write
);

    sp_cmd_e             cmd;
    logic                write_ok;
    logic [SP_WIDTH-1:0] sp_d, sp_q;

    assign cmd = decode_cmd(load_sp, write_sp, inc_sp);

`ifdef STATIC_POINTER_RANGE_CHECK_EN
    logic in_range;
    logic inv_d, inv_q;

    sp_range_check #(
        .WIDTH(SP_WIDTH)
    ) u_range_check (
        .value   (sp_data_in),
        .base    (SP_BASE),
        .limit   (SP_LIMIT),
        .in_range(in_range)
    );

    assign write_ok = in_range;

    // Any cycle other than a rejected write clears the flag, so it is a one-cycle pulse.
    always_comb begin
        inv_d = (cmd == CMD_WRITE) && !in_range;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign invalid_write = inv_q;
`else
    // Window parameters have no effect in this build.
    logic unused_range;
    assign unused_range  = ^{SP_BASE, SP_LIMIT};
    assign write_ok      = 1'b1;
    assign invalid_write = 1'b0;
`endif

    always_comb begin
        sp_d = sp_q;
        unique case (cmd)
            CMD_LOAD:  sp_d = sp_data_in;
            CMD_WRITE: if (write_ok) sp_d = sp_data_in;
            CMD_INC:   sp_d = sp_q + 1'b1;
            default:   sp_d = sp_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= SP_RESET;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_data_out = sp_q;

endmodule

// File: tb/tb_static_pointer.sv
// tb_static_pointer: directed plus randomized check of static_pointer against a
// behavioural model. Honours STATIC_POINTER_RANGE_CHECK_EN like the design.
module tb_static_pointer;
    import static_pointer_pkg::*;

`ifdef STATIC_POINTER_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        load_sp, inc_sp, write_sp;
    logic [15:0] sp_data_in;
    logic [15:0] sp_data_out;
    logic        invalid_write;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [15:0] m_sp;
    logic        m_inv;

    static_pointer #(
        .SP_BASE (16'h2800),
        .SP_LIMIT(16'h2FFF),
        .SP_RESET(16'h2800)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_sp      (load_sp),
        .inc_sp       (inc_sp),
        .write_sp     (write_sp),
        .sp_data_in   (sp_data_in),
        .sp_data_out  (sp_data_out),
        .invalid_write(invalid_write)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behaviour straight from the command rules: highest asserted command wins.
    task automatic model_step(input logic l, input logic w, input logic i,
                              input logic [15:0] d);
        bit legal;
        legal = !RangeCheck || (int'(d) >= 'h2800 && int'(d) <= 'h2FFF);
        m_inv = 1'b0;
        if (l) begin
            m_sp = d;
        end else if (w) begin
            if (legal) m_sp = d;
            else       m_inv = 1'b1;
        end else if (i) begin
            m_sp = 16'((int'(m_sp) + 1) % 65536);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, " sp"}, 32'(sp_data_out), 32'(m_sp));
        check_eq({tag, " inv"}, 32'(invalid_write), 32'(m_inv));
    endtask

    // Called at posedge+1; applies a command across the next edge and checks.
    task automatic step(input logic l, input logic w, input logic i, input logic [15:0] d,
                        input string tag);
        load_sp    = l;
        write_sp   = w;
        inc_sp     = i;
        sp_data_in = d;
        @(posedge clk);
        model_step(l, w, i, d);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [15:0] pick_data();
        case ($urandom_range(0, 6))
            0: return 16'h2800;
            1: return 16'h2FFF;
            2: return 16'h3000;
            3: return 16'h27FF;
            4: return 16'hFFFF;
            5: return 16'(16'h2800 + $urandom_range(0, 16'h7FF));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        load_sp    = 1'b0;
        write_sp   = 1'b0;
        inc_sp     = 1'b0;
        sp_data_in = 16'h0;
        m_sp       = 16'h2800;
        m_inv      = 1'b0;

        // Asynchronous reset: visible before any clock edge
        #1;
        check_outputs("reset async");
        // Commands during reset are ignored across the edge at t=5
        load_sp    = 1'b1;
        inc_sp     = 1'b1;
        sp_data_in = 16'h1111;
        #9;
        check_outputs("reset hold");
        reset   = 1'b0;
        load_sp = 1'b0;
        inc_sp  = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post reset idle");

        // Directed sequence
        step(1'b1, 1'b0, 1'b0, 16'h2800, "load 2800");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc");
        step(1'b0, 1'b1, 1'b0, 16'hABCD, "write abcd");
        check_eq("write abcd direct", 32'(sp_data_out), RangeCheck ? 32'h2801 : 32'hABCD);
        step(1'b1, 1'b0, 1'b0, 16'h3200, "load 3200");

        // Window edges, each followed by an idle cycle to see the pulse end
        step(1'b0, 1'b1, 1'b0, 16'h2FFF, "write 2fff");
        step(1'b0, 1'b1, 1'b0, 16'h3000, "write 3000");
        step(1'b0, 1'b0, 1'b0, 16'h0000, "idle after 3000");
        step(1'b0, 1'b1, 1'b0, 16'h27FF, "write 27ff");
        step(1'b0, 1'b0, 1'b0, 16'h0000, "idle after 27ff");
        step(1'b0, 1'b1, 1'b0, 16'h2800, "write 2800");

        // Wrap
        step(1'b1, 1'b0, 1'b0, 16'hFFFF, "load ffff");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc wrap");
        check_eq("inc wrap direct", 32'(sp_data_out), 32'h0000);

        // Simultaneous commands
        step(1'b1, 1'b1, 1'b1, 16'h1234, "all three");
        step(1'b0, 1'b1, 1'b1, 16'h5000, "write+inc");
        step(1'b0, 1'b1, 1'b1, 16'h2A00, "write+inc ok");

        // Reset asserted between edges
        step(1'b0, 1'b1, 1'b0, 16'h3001, "pre reset");
        #3;
        reset = 1'b1;
        #1;
        m_sp  = 16'h2800;
        m_inv = 1'b0;
        check_outputs("mid reset");
        load_sp    = 1'b1;
        sp_data_in = 16'h4444;
        @(posedge clk);
        #1;
        check_outputs("mid reset hold");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        model_step(1'b1, 1'b0, 1'b0, 16'h4444);
        #1;
        check_outputs("first edge after reset");

        // Randomized
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), pick_data(), "rand");
        end

        load_sp  = 1'b0;
        write_sp = 1'b0;
        inc_sp   = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
